// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared encodings for the branch unit
// Purpose: branch condition codes (funct3) and the output-register state encoding.
package branch_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - funct3 to branch-taken decode
// Purpose: purely combinational condition evaluation from precomputed comparator flags.
// Ports:
//   funct3  : branch condition code
//   eq/ls/lu: rs1 vs rs2 equal, signed-less, unsigned-less
//   taken   : condition holds (0 for reserved codes)
//   illegal : funct3 is a reserved branch encoding
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       ls,
    input  logic       lu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = ls;
            F3_BGE:  taken = !ls;
            F3_BLTU: taken = lu;
            F3_BGEU: taken = !lu;
            F3_RSV2: illegal = 1'b1;
            F3_RSV3: illegal = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch/jump resolution with a one-entry output register
// Purpose: resolves taken/target/link for branch, JAL and JALR, flags misalignment and
// reserved encodings, detects mispredicts and counts them.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid / in_ready        : upstream handshake
//   is_branch, is_jal, is_jalr : instruction class (at most one set)
//   funct3, pc, imm, rs1       : instruction fields and rs1 value
//   eq, ls, lu                 : comparator flags for rs1 vs rs2
//   pred_taken                 : fetch-stage prediction
//   out_valid / out_ready      : downstream handshake
//   taken, target, link        : resolved direction, target address, return address
//   misaligned, illegal        : taken target not word aligned, reserved branch funct3
//   flush                      : one-cycle mispredict pulse
//   mispred_cnt                : saturating mispredict count
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic             eq,
    input  logic             ls,
    input  logic             lu,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  link,
    output logic             misaligned,
    output logic             illegal,
    output logic             flush,
    output logic [CNT_W-1:0] mispred_cnt
);

    state_t state;
    state_t state_next;

    logic            accept;
    logic            cond_taken;
    logic            cond_illegal;
    logic            taken_c;
    logic            illegal_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;
    logic            misaligned_c;
    logic            mispred_c;

    branch_cond u_cond (
        .funct3  (funct3),
        .eq      (eq),
        .ls      (ls),
        .lu      (lu),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    // Ready only depends on the output register, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        if (is_branch) begin
            taken_c   = cond_taken;
            illegal_c = cond_illegal;
        end else if (is_jal || is_jalr) begin
            taken_c = 1'b1;
        end
    end

    // JALR clears bit 0 of rs1+imm; all additions wrap at XLEN bits.
    always_comb begin
        target_c = pc + imm;
        if (is_jalr) begin
            target_c = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end
    end

    assign link_c       = pc + XLEN'(4);
    assign misaligned_c = taken_c && target_c[1];
    assign mispred_c    = taken_c != pred_taken;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state == ST_FULL);
    end

    // Result register: loads only on accept, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken      <= 1'b0;
            target     <= '0;
            link       <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            taken      <= taken_c;
            target     <= target_c;
            link       <= link_c;
            misaligned <= misaligned_c;
            illegal    <= illegal_c;
        end
    end

    // Flush rises with the first out_valid cycle of a mispredicted result; a stall
    // blocks further accepts, so it drops after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush <= 1'b0;
        end else begin
            flush <= accept && mispred_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (accept && mispred_c && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule
